// File: rtl/pipeline_ctrl_if.sv
// Status/control bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             idex_dREN;
  logic [4:0]       idex_wsel;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             branch_mem;
  logic             halt_mem;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, id_rs, id_rt, idex_dREN, idex_wsel,
           exmem_dREN, exmem_dWEN, branch_mem, halt_mem,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, id_rs, id_rt, idex_dREN, idex_wsel,
           exmem_dREN, exmem_dWEN, branch_mem, halt_mem,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: per-latch enable/flush and PC enable decided combinationally,
// with a RUN/MEMWAIT/HALTED FSM and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

  state_t           state_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic mem_pend;
  logic loaduse;
  logic halt_take;
  logic pend_take;
  logic branch_take;
  logic stall_inc;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign mem_pend = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
  assign loaduse  = bus.idex_dREN & (bus.idex_wsel != 5'd0) &
                    ((bus.idex_wsel == bus.id_rs) | (bus.idex_wsel == bus.id_rt));

  // MEMWAIT resolves through mem_pend itself, so RUN and MEMWAIT share one priority chain.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halt_take   = 1'b0;
    pend_take   = 1'b0;
    branch_take = 1'b0;
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (bus.halt_mem) begin
      halt_take   = 1'b1;
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_pend) begin
      pend_take   = 1'b1;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (bus.branch_mem) begin
      branch_take = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (loaduse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!bus.ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign stall_inc = (state_q != HALTED) & ~pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q != HALTED) begin
        if (halt_take) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end else if (pend_take) begin
          state_q <= MEMWAIT;
        end else begin
          state_q <= RUN;
        end
      end
      if (stall_inc && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (branch_take && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halted      = halted_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model queues the expected control vector
// and registered state per cycle; DUT outputs are popped and compared.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic [8:0]       ctrl;
    logic             halted;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int               m_state;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] obs_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic dh, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ldr, input logic [4:0] ws, input logic mr, input logic mw,
                       input logic br, input logic hl);
    bus.ihit = ih; bus.dhit = dh; bus.id_rs = rs; bus.id_rt = rt;
    bus.idex_dREN = ldr; bus.idex_wsel = ws; bus.exmem_dREN = mr;
    bus.exmem_dWEN = mw; bus.branch_mem = br; bus.halt_mem = hl;
  endtask

  // One clock cycle: drive, model, push; then pop and compare comb then registered outputs.
  task automatic cyc(input string tag, input logic ih, input logic dh, input logic [4:0] rs,
                     input logic [4:0] rt, input logic ldr, input logic [4:0] ws,
                     input logic mr, input logic mw, input logic br, input logic hl);
    logic pend, lu, brt;
    exp_t e;
    exp_t p;
    logic [8:0] oc;
    @(negedge CLK);
    drive(ih, dh, rs, rt, ldr, ws, mr, mw, br, hl);
    pend = (mr | mw) & ~dh;
    lu   = ldr && (ws != 5'd0) && (ws == rs || ws == rt);
    brt  = 1'b0;
    if (m_state == 2)  e.ctrl = 9'b0_0000_0000;
    else if (hl)       e.ctrl = 9'b0_1111_1110;
    else if (pend)     e.ctrl = 9'b0_0001_0001;
    else if (br) begin e.ctrl = 9'b1_1111_1110; brt = 1'b1; end
    else if (lu)       e.ctrl = 9'b0_0111_0100;
    else if (!ih)      e.ctrl = 9'b0_1111_1000;
    else               e.ctrl = 9'b1_1111_0000;
    if (m_state != 2) begin
      if (!e.ctrl[8] && m_stall != CMAX) m_stall++;
      if (brt && m_flush != CMAX) m_flush++;
      m_state = hl ? 2 : (pend ? 1 : 0);
    end
    e.halted = (m_state == 2);
    e.stall  = m_stall;
    e.flush  = m_flush;
    sb_q.push_back(e);
    #2;
    oc = obs_ctrl();
    @(posedge CLK);
    #1;
    p = sb_q.pop_front();
    check({tag, ".ctrl"}, 32'(oc), 32'(p.ctrl));
    check({tag, ".halted"}, 32'(bus.halted), 32'(p.halted));
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(p.stall));
    check({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(p.flush));
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must show the reset pattern immediately.
  task automatic apply_reset(input string tag);
    @(negedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    check({tag, ".rst_ctrl"}, 32'(obs_ctrl()), 32'(9'b0_0000_1111));
    check({tag, ".rst_halted"}, 32'(bus.halted), 32'd0);
    check({tag, ".rst_stall"}, 32'(bus.stall_cnt), 32'd0);
    check({tag, ".rst_flush"}, 32'(bus.flush_cnt), 32'd0);
    m_state = 0;
    m_stall = '0;
    m_flush = '0;
    @(posedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    m_state = 0;
    m_stall = '0;
    m_flush = '0;
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("por.ctrl", 32'(obs_ctrl()), 32'(9'b0_0000_1111));
    check("por.stall", 32'(bus.stall_cnt), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    idle("run_default");

    // load-use on rs, then on rt, then wsel=0 which must not stall
    cyc("loaduse_rs", 1'b1, 1'b0, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("after_loaduse");
    cyc("loaduse_rt", 1'b1, 1'b0, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("wsel_zero", 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("no_load", 1'b1, 1'b0, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // memory wait: three pending cycles, then dhit releases
    apply_reset("memwait");
    for (int i = 0; i < 3; i++)
      cyc("mem_pend", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mem_done", 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("after_mem");
    cyc("store_pend", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("store_done_br", 1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    // branch beats load-use; branch during pending memory is deferred
    apply_reset("branch");
    cyc("branch_lu", 1'b1, 1'b0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("after_branch");
    cyc("branch_pend", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("branch_go", 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("imiss", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a memory wait
    cyc("pre_rst_pend", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_reset("mid_memwait");
    idle("post_rst_run");

    // stall counter saturation
    for (int i = 0; i < 20; i++)
      cyc("imiss_sat", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++)
      cyc("flush_sat", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // halt from MEMWAIT wins over pending memory, then sticky under random inputs
    apply_reset("halt");
    cyc("halt_pend", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("halt", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      cyc("halted", 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    apply_reset("unhalt");
    idle("unhalt_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
